// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution block: condition codes,
// flag bit positions inside {N,Z,C,V}, and FlagW bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against the
// stored NZCV flags. The NV encoding is treated as "never".
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // Condition table lookup
  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage between the decoder and the datapath write
// enables. Holds the NZCV register, gates PC/register/memory writes with the
// condition result, and keeps saturating debug counters.
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             Pcs,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             cnt_clr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt,
  output logic [CNT_W-1:0] br_cnt
);

  localparam int NUM_CNT = 3;
  localparam int CNT_EXEC = 0;
  localparam int CNT_SQUASH = 1;
  localparam int CNT_BR = 2;

  logic [3:0]         flags_reg;
  logic               cond_ex;
  logic               ok;
  logic [NUM_CNT-1:0] cnt_inc;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_reg),
    .CondEx (cond_ex)
  );

  // Gating is zero-latency: it uses the flags stored before this instruction
  assign ok       = en & cond_ex;
  assign CondEx   = cond_ex;
  assign PCSrc    = Pcs & ok;
  assign RegWrite = RegW & ok & ~NoWrite;
  assign MemWrite = MemW & ok;
  assign Flags    = flags_reg;

  // Flag register: each FlagW bit independently loads its pair when executed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= 4'b0000;
    end else if (ok) begin
      if (FlagW[FW_NZ]) begin
        flags_reg[FLAG_N] <= ALUFlags[FLAG_N];
        flags_reg[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[FW_CV]) begin
        flags_reg[FLAG_C] <= ALUFlags[FLAG_C];
        flags_reg[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  // Increment requests; all are qualified by en so bubbles are never counted
  assign cnt_inc[CNT_EXEC]   = ok;
  assign cnt_inc[CNT_SQUASH] = en & ~cond_ex;
  assign cnt_inc[CNT_BR]     = ok & Pcs;

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Saturating counter; clear wins over increment on the same edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign exec_cnt   = g_cnt[CNT_EXEC].cnt_reg;
  assign squash_cnt = g_cnt[CNT_SQUASH].cnt_reg;
  assign br_cnt     = g_cnt[CNT_BR].cnt_reg;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios with literal
// expectations plus randomized instructions checked every cycle against a
// behavioural model of the flags, condition rules and counters.
module tb_cond_logic;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             Pcs;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             cnt_clr;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;
  logic [CNT_W-1:0] br_cnt;

  int tests = 0;
  int fails = 0;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .Pcs        (Pcs),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .cnt_clr    (cnt_clr),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .CondEx     (CondEx),
    .Flags      (Flags),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt),
    .br_cnt     (br_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Conditions come in base/inverse pairs: odd codes negate the even code.
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);   // AL always, NV never
    endcase
    return c[0] ? !base : base;
  endfunction

  logic [3:0] m_flags;
  int m_exec, m_squash, m_br;

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags  <= 4'b0000;
      m_exec   <= 0;
      m_squash <= 0;
      m_br     <= 0;
    end else begin
      if (en && m_cond(Cond, m_flags)) begin
        m_flags <= {FlagW[1] ? ALUFlags[3:2] : m_flags[3:2],
                    FlagW[0] ? ALUFlags[1:0] : m_flags[1:0]};
      end
      if (cnt_clr) begin
        m_exec <= 0; m_squash <= 0; m_br <= 0;
      end else if (en) begin
        if (m_cond(Cond, m_flags)) begin
          m_exec <= sat(m_exec);
          if (Pcs) m_br <= sat(m_br);
        end else begin
          m_squash <= sat(m_squash);
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    bit ok;
    ok = en && m_cond(Cond, m_flags);
    check("CondEx",     int'(CondEx),     int'(m_cond(Cond, m_flags)));
    check("PCSrc",      int'(PCSrc),      int'(Pcs && ok));
    check("RegWrite",   int'(RegWrite),   int'(RegW && ok && !NoWrite));
    check("MemWrite",   int'(MemWrite),   int'(MemW && ok));
    check("Flags",      int'(Flags),      int'(m_flags));
    check("exec_cnt",   int'(exec_cnt),   m_exec);
    check("squash_cnt", int'(squash_cnt), m_squash);
    check("br_cnt",     int'(br_cnt),     m_br);
    $display("[TB] cyc t=%0t en=%0b cond=%h flags=%h condex=%0b pcsrc=%0b rw=%0b mw=%0b cnt=%0d/%0d/%0d",
             $time, en, Cond, Flags, CondEx, PCSrc, RegWrite, MemWrite, exec_cnt, squash_cnt, br_cnt);
  end

  // ---------------- stimulus ----------------
  // Inputs change at posedge+1; settle #2 so callers can check combinational outputs
  task automatic set_in(input bit e, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input bit p, input bit rw,
                        input bit mw, input bit nw, input bit clr);
    en = e; Cond = c; ALUFlags = af; FlagW = fw; Pcs = p;
    RegW = rw; MemW = mw; NoWrite = nw; cnt_clr = clr;
    #2;
  endtask

  task automatic edge_step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    set_in(1, 4'b1110, f, 2'b11, 0, 0, 0, 0, 0);
    edge_step();
  endtask

  task automatic clear_cnts;
    set_in(0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    edge_step();
  endtask

  initial begin
    logic [3:0] sv_flags;
    int sv_e, sv_s, sv_b;

    rst_n = 1'b0;
    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", int'(Flags), 0);
    check("reset_exec",  int'(exec_cnt), 0);
    rst_n = 1'b1;
    edge_step();

    // CMP then BEQ
    clear_cnts();
    set_in(1, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1, 0);
    check("cmp_regwrite", int'(RegWrite), 0);
    check("cmp_condex",   int'(CondEx), 1);
    edge_step();
    check("cmp_flags", int'(Flags), 4'b0110);
    set_in(1, 4'b0000, 4'h0, 2'b00, 1, 0, 0, 0, 0);
    check("beq_pcsrc", int'(PCSrc), 1);
    edge_step();
    check("beq_brcnt", int'(br_cnt), 1);

    // Failed condition leaves flags alone even with FlagW=11
    set_flags(4'b0000);
    clear_cnts();
    set_in(1, 4'b0000, 4'b1111, 2'b11, 0, 1, 1, 0, 0);
    check("fail_regwrite", int'(RegWrite), 0);
    check("fail_memwrite", int'(MemWrite), 0);
    edge_step();
    check("fail_flags",  int'(Flags), 0);
    check("fail_squash", int'(squash_cnt), 1);

    // Partial flag write: only N,Z loaded
    set_flags(4'b1111);
    set_in(1, 4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0, 0);
    edge_step();
    check("partial_flags", int'(Flags), 4'b0011);

    // Condition sweep with en=0 so flags hold while every code is tried
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        set_in(0, 4'(c), 4'h0, 2'b00, 0, 0, 0, 0, 0);
        if (f == 4'b1000 && c == 4'b1010) check("sweep_ge_nv", int'(CondEx), 0);
        if (f == 4'b1000 && c == 4'b1011) check("sweep_lt_nv", int'(CondEx), 1);
        if (f == 4'b0001 && c == 4'b1100) check("sweep_gt_nv", int'(CondEx), 0);
        if (f == 4'b0001 && c == 4'b1101) check("sweep_le_nv", int'(CondEx), 1);
        if (c == 15) check("sweep_nv", int'(CondEx), 0);
        edge_step();
      end
    end

    // Saturation
    clear_cnts();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0);
      edge_step();
    end
    check("sat_exec", int'(exec_cnt), 15);

    // Clear beats increment
    set_in(1, 4'b1110, 4'h0, 2'b00, 1, 0, 0, 0, 1);
    edge_step();
    check("clr_exec", int'(exec_cnt), 0);
    check("clr_br",   int'(br_cnt), 0);

    // Bubble: no outputs, no state change
    set_flags(4'b0101);
    sv_flags = Flags; sv_e = exec_cnt; sv_s = squash_cnt; sv_b = br_cnt;
    set_in(0, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 0, 0);
    check("bub_pcsrc", int'(PCSrc), 0);
    check("bub_regw",  int'(RegWrite), 0);
    check("bub_memw",  int'(MemWrite), 0);
    edge_step();
    check("bub_flags",  int'(Flags), int'(sv_flags));
    check("bub_exec",   int'(exec_cnt), sv_e);
    check("bub_squash", int'(squash_cnt), sv_s);
    check("bub_br",     int'(br_cnt), sv_b);

    // Asynchronous reset mid-stream
    set_flags(4'b1111);
    set_in(1, 4'b1110, 4'h0, 2'b00, 1, 0, 0, 0, 0);
    edge_step();
    rst_n = 1'b0;
    #1;
    check("arst_flags",  int'(Flags), 0);
    check("arst_exec",   int'(exec_cnt), 0);
    check("arst_squash", int'(squash_cnt), 0);
    check("arst_br",     int'(br_cnt), 0);
    edge_step();
    rst_n = 1'b1;
    set_in(1, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    check("post_rst_eq", int'(CondEx), 0);
    set_in(1, 4'b0001, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    check("post_rst_ne", int'(CondEx), 1);
    edge_step();

    // Randomized instruction stream
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 31) == 0));
      edge_step();
    end

    set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
